serial_adder: RTL

- Parametrised multi-cycle adder built around the team's fulladder slice.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first.
- Operands are accepted with a start/busy/done handshake.
- Successor to the single-bit combinational full adder. Trades latency for area in datapaths that cannot afford a full WIDTH-bit ripple chain.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus for serial_adder.
// Optional feature macro SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, e1, e2, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, e1, e2, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, e1, e2, cin, input busy, done, sum, cout);
    modport slave  (input start, e1, e2, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock, LSB first, built from a
// ripple of full-adder slices. WIDTH >= 2 and DIGIT must divide WIDTH.
// Optional feature macro SERIAL_ADDER_SUB_EN: 'sub' request computes e1 - e2,
// with cout=1 meaning no borrow.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] s_digit_c;
    logic             c_out_c;
    logic [WIDTH-1:0] r_next_c;
    logic [WIDTH-1:0] b_load_c;
    logic             c_load_c;

    // Digit adder: chain of DIGIT full-adder slices fed by the carry register.
    always_comb begin
        logic [DIGIT:0] ch;
        ch        = '0;
        ch[0]     = carry;
        s_digit_c = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s_digit_c[i] = a_sr[i] ^ b_sr[i] ^ ch[i];
            ch[i+1]      = (a_sr[i] & b_sr[i]) | (ch[i] & (a_sr[i] ^ b_sr[i]));
        end
        c_out_c  = ch[DIGIT];
        r_next_c = (r_sr >> DIGIT) | (WIDTH'(s_digit_c) << (WIDTH - DIGIT));
    end

    // Operand B and initial carry as loaded on an accepted start.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load_c = bus.sub ? ~bus.e2 : bus.e2;
        c_load_c = bus.sub ? 1'b1 : bus.cin;
`else
        b_load_c = bus.e2;
        c_load_c = bus.cin;
`endif
    end

    // Control FSM with datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.e1;
                        b_sr     <= b_load_c;
                        carry    <= c_load_c;
                        r_sr     <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    r_sr  <= r_next_c;
                    carry <= c_out_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= r_next_c;
                        bus.cout <= c_out_c;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
